// File: rtl/alu_cdb_unit_if.sv
// Dispatch and result-bus signals between reservation station, ALU execution stage and CDB.
// The unit uses the slave modport. The dispatcher/CDB side uses the master modport.
interface alu_cdb_unit_if #(
    parameter int ROB_LOG = 4,
    parameter int OP_LOG  = 6
);
    logic               FU_enable;
    logic [OP_LOG-1:0]  FU_op;
    logic [31:0]        FU_Vj;
    logic [31:0]        FU_Vk;
    logic [31:0]        FU_Imm;
    logic [ROB_LOG-1:0] FU_DestRob;
    logic [31:0]        FU_CurPC;
    logic               cdb_ready;

    logic               exc_valid;
    logic [ROB_LOG-1:0] exc_RobId;
    logic [31:0]        exc_value;
    logic               exc_jump;
    logic [31:0]        exc_target;

    modport master (
        output FU_enable, FU_op, FU_Vj, FU_Vk, FU_Imm, FU_DestRob, FU_CurPC, cdb_ready,
        input  exc_valid, exc_RobId, exc_value, exc_jump, exc_target
    );

    modport slave (
        input  FU_enable, FU_op, FU_Vj, FU_Vk, FU_Imm, FU_DestRob, FU_CurPC, cdb_ready,
        output exc_valid, exc_RobId, exc_value, exc_jump, exc_target
    );
endinterface

// File: rtl/alu_cdb_unit.sv
// ALU/branch execution stage: computes one micro-op per cycle into an in-order result FIFO drained onto the CDB.
// Latency 1 cycle dispatch-to-broadcast; head holds while cdb_ready=0, pushes into a full FIFO are dropped and flagged.
module alu_cdb_unit #(
    parameter int ROB_LOG    = 4,
    parameter int OP_LOG     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          jump_flag,
    alu_cdb_unit_if.slave bus,
    output logic          alu_next_full,
    output logic          ovf_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [OP_LOG-1:0] OP_ADD   = OP_LOG'(0);
    localparam logic [OP_LOG-1:0] OP_SUB   = OP_LOG'(1);
    localparam logic [OP_LOG-1:0] OP_SLL   = OP_LOG'(2);
    localparam logic [OP_LOG-1:0] OP_SLT   = OP_LOG'(3);
    localparam logic [OP_LOG-1:0] OP_SLTU  = OP_LOG'(4);
    localparam logic [OP_LOG-1:0] OP_XOR   = OP_LOG'(5);
    localparam logic [OP_LOG-1:0] OP_SRL   = OP_LOG'(6);
    localparam logic [OP_LOG-1:0] OP_SRA   = OP_LOG'(7);
    localparam logic [OP_LOG-1:0] OP_OR    = OP_LOG'(8);
    localparam logic [OP_LOG-1:0] OP_AND   = OP_LOG'(9);
    localparam logic [OP_LOG-1:0] OP_ADDI  = OP_LOG'(10);
    localparam logic [OP_LOG-1:0] OP_SLTI  = OP_LOG'(11);
    localparam logic [OP_LOG-1:0] OP_SLTIU = OP_LOG'(12);
    localparam logic [OP_LOG-1:0] OP_XORI  = OP_LOG'(13);
    localparam logic [OP_LOG-1:0] OP_ORI   = OP_LOG'(14);
    localparam logic [OP_LOG-1:0] OP_ANDI  = OP_LOG'(15);
    localparam logic [OP_LOG-1:0] OP_SLLI  = OP_LOG'(16);
    localparam logic [OP_LOG-1:0] OP_SRLI  = OP_LOG'(17);
    localparam logic [OP_LOG-1:0] OP_SRAI  = OP_LOG'(18);
    localparam logic [OP_LOG-1:0] OP_LUI   = OP_LOG'(19);
    localparam logic [OP_LOG-1:0] OP_AUIPC = OP_LOG'(20);
    localparam logic [OP_LOG-1:0] OP_JAL   = OP_LOG'(21);
    localparam logic [OP_LOG-1:0] OP_JALR  = OP_LOG'(22);
    localparam logic [OP_LOG-1:0] OP_BEQ   = OP_LOG'(23);
    localparam logic [OP_LOG-1:0] OP_BNE   = OP_LOG'(24);
    localparam logic [OP_LOG-1:0] OP_BLT   = OP_LOG'(25);
    localparam logic [OP_LOG-1:0] OP_BGE   = OP_LOG'(26);
    localparam logic [OP_LOG-1:0] OP_BLTU  = OP_LOG'(27);
    localparam logic [OP_LOG-1:0] OP_BGEU  = OP_LOG'(28);

    typedef struct packed {
        logic [ROB_LOG-1:0] rob;
        logic [31:0]        value;
        logic               jump;
        logic [31:0]        target;
    } entry_t;

    // ---------------- compute ----------------
    logic [31:0] vj, vk, imm, pc;
    logic [31:0] pc_plus4, pc_plus_imm, vj_plus_imm;
    logic [4:0]  sh_r, sh_i;
    logic [31:0] res_value;
    logic        res_jump;
    logic        res_branch;
    logic [31:0] res_target;

    assign vj          = bus.FU_Vj;
    assign vk          = bus.FU_Vk;
    assign imm         = bus.FU_Imm;
    assign pc          = bus.FU_CurPC;
    assign pc_plus4    = pc + 32'd4;
    assign pc_plus_imm = pc + imm;
    assign vj_plus_imm = vj + imm;
    assign sh_r        = vk[4:0];
    assign sh_i        = imm[4:0];

    always_comb begin
        res_value  = '0;
        res_jump   = 1'b0;
        res_branch = 1'b0;
        res_target = pc_plus4;
        case (bus.FU_op)
            OP_ADD:   res_value = vj + vk;
            OP_SUB:   res_value = vj - vk;
            OP_SLL:   res_value = vj << sh_r;
            OP_SLT:   res_value = {31'd0, $signed(vj) < $signed(vk)};
            OP_SLTU:  res_value = {31'd0, vj < vk};
            OP_XOR:   res_value = vj ^ vk;
            OP_SRL:   res_value = vj >> sh_r;
            OP_SRA:   res_value = $unsigned($signed(vj) >>> sh_r);
            OP_OR:    res_value = vj | vk;
            OP_AND:   res_value = vj & vk;
            OP_ADDI:  res_value = vj_plus_imm;
            OP_SLTI:  res_value = {31'd0, $signed(vj) < $signed(imm)};
            OP_SLTIU: res_value = {31'd0, vj < imm};
            OP_XORI:  res_value = vj ^ imm;
            OP_ORI:   res_value = vj | imm;
            OP_ANDI:  res_value = vj & imm;
            OP_SLLI:  res_value = vj << sh_i;
            OP_SRLI:  res_value = vj >> sh_i;
            OP_SRAI:  res_value = $unsigned($signed(vj) >>> sh_i);
            OP_LUI:   res_value = imm;
            OP_AUIPC: res_value = pc_plus_imm;
            OP_JAL: begin
                res_value  = pc_plus4;
                res_jump   = 1'b1;
                res_target = pc_plus_imm;
            end
            OP_JALR: begin
                res_value  = pc_plus4;
                res_jump   = 1'b1;
                res_target = vj_plus_imm & ~32'd1;
            end
            OP_BEQ: begin res_branch = 1'b1; res_jump = (vj == vk);                  end
            OP_BNE: begin res_branch = 1'b1; res_jump = (vj != vk);                  end
            OP_BLT: begin res_branch = 1'b1; res_jump = ($signed(vj) <  $signed(vk)); end
            OP_BGE: begin res_branch = 1'b1; res_jump = ($signed(vj) >= $signed(vk)); end
            OP_BLTU: begin res_branch = 1'b1; res_jump = (vj <  vk);                  end
            OP_BGEU: begin res_branch = 1'b1; res_jump = (vj >= vk);                  end
            default: ;
        endcase
        if (res_branch && res_jump) res_target = pc_plus_imm;
    end

    // ---------------- result FIFO ----------------
    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               full, empty;
    logic               do_pop, do_push, drop;
    entry_t             wr_entry, head_entry;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = rdy && !jump_flag && !empty && bus.cdb_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = rdy && !jump_flag && bus.FU_enable && (!full || do_pop);
    assign drop    = rdy && !jump_flag && bus.FU_enable && full && !do_pop;

    assign wr_entry = '{rob: bus.FU_DestRob, value: res_value, jump: res_jump, target: res_target};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_err <= 1'b0;
        end else if (rdy) begin
            if (jump_flag) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) tail_q <= tail_q + PTR_W'(1);
                if (do_pop)  head_q <= head_q + PTR_W'(1);
                if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
                else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
                if (drop) ovf_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: every read is qualified by a nonzero count.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_q] <= wr_entry;
    end

    assign head_entry = mem[head_q];

    assign bus.exc_valid  = !empty;
    assign bus.exc_RobId  = empty ? '0    : head_entry.rob;
    assign bus.exc_value  = empty ? 32'd0 : head_entry.value;
    assign bus.exc_jump   = !empty && head_entry.jump;
    assign bus.exc_target = empty ? 32'd0 : head_entry.target;

    assign alu_next_full = (count_q >= CNT_W'(FIFO_DEPTH - 1));
endmodule

// File: tb/tb_alu_cdb_unit.sv
// Directed bench for alu_cdb_unit: vector table for the compute paths plus sequences for FIFO corner cases.
module tb_alu_cdb_unit;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic jump_flag;
    logic alu_next_full;
    logic ovf_err;

    int checks = 0;
    int errors = 0;

    alu_cdb_unit_if #(.ROB_LOG(4), .OP_LOG(6)) bus ();

    alu_cdb_unit #(.ROB_LOG(4), .OP_LOG(6), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .jump_flag     (jump_flag),
        .bus           (bus),
        .alu_next_full (alu_next_full),
        .ovf_err       (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
        logic [31:0] exp_value;
        logic        exp_jump;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [5:0] op, input logic [31:0] vj,
                         input logic [31:0] vk, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] rob);
        bus.FU_enable  = en;
        bus.FU_op      = op;
        bus.FU_Vj      = vj;
        bus.FU_Vk      = vk;
        bus.FU_Imm     = imm;
        bus.FU_CurPC   = pc;
        bus.FU_DestRob = rob;
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        jump_flag = 1'b0;
        bus.cdb_ready = 1'b0;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);

        //          op     vj            vk            imm           pc            rob  value         jump  target
        vecs.push_back('{6'd0,  32'd7,        32'hFFFFFFFF, 32'd0,        32'h0,        4'd3, 32'd6,        1'b0, 32'h4});
        vecs.push_back('{6'd1,  32'd5,        32'd7,        32'd0,        32'h10,       4'd1, 32'hFFFFFFFE, 1'b0, 32'h14});
        vecs.push_back('{6'd2,  32'd1,        32'h24,       32'd0,        32'h0,        4'd2, 32'h10,       1'b0, 32'h4});
        vecs.push_back('{6'd3,  32'hFFFFFFFE, 32'd1,        32'd0,        32'h0,        4'd4, 32'd1,        1'b0, 32'h4});
        vecs.push_back('{6'd4,  32'hFFFFFFFE, 32'd1,        32'd0,        32'h0,        4'd5, 32'd0,        1'b0, 32'h4});
        vecs.push_back('{6'd7,  32'h80000000, 32'd4,        32'd0,        32'h0,        4'd6, 32'hF8000000, 1'b0, 32'h4});
        vecs.push_back('{6'd6,  32'h80000000, 32'd4,        32'd0,        32'h0,        4'd7, 32'h08000000, 1'b0, 32'h4});
        vecs.push_back('{6'd18, 32'h80000000, 32'd0,        32'h21,       32'h0,        4'd8, 32'hC0000000, 1'b0, 32'h4});
        vecs.push_back('{6'd13, 32'hF0F0,     32'd0,        32'hFF,       32'h0,        4'd9, 32'hF00F,     1'b0, 32'h4});
        vecs.push_back('{6'd12, 32'd1,        32'd0,        32'hFFFFFFFF, 32'h0,        4'd10, 32'd1,       1'b0, 32'h4});
        vecs.push_back('{6'd15, 32'hFFFF,     32'd0,        32'h0F0F,     32'h0,        4'd11, 32'h0F0F,    1'b0, 32'h4});
        vecs.push_back('{6'd19, 32'd0,        32'd0,        32'h12345000, 32'h0,        4'd12, 32'h12345000, 1'b0, 32'h4});
        vecs.push_back('{6'd20, 32'd0,        32'd0,        32'h2000,     32'h1000,     4'd13, 32'h3000,    1'b0, 32'h1004});
        vecs.push_back('{6'd21, 32'd0,        32'd0,        32'hFFFFFFF0, 32'h200,      4'd14, 32'h204,     1'b1, 32'h1F0});
        vecs.push_back('{6'd22, 32'h1003,     32'd0,        32'd4,        32'h40,       4'd15, 32'h44,      1'b1, 32'h1006});
        vecs.push_back('{6'd25, 32'hFFFFFFFE, 32'd1,        32'h20,       32'h100,      4'd1, 32'd0,        1'b1, 32'h120});
        vecs.push_back('{6'd27, 32'hFFFFFFFE, 32'd1,        32'h20,       32'h100,      4'd2, 32'd0,        1'b0, 32'h104});
        vecs.push_back('{6'd23, 32'd5,        32'd5,        32'd8,        32'h300,      4'd3, 32'd0,        1'b1, 32'h308});
        vecs.push_back('{6'd28, 32'd1,        32'hFFFFFFFF, 32'h40,       32'h0,        4'd4, 32'd0,        1'b0, 32'h4});
        vecs.push_back('{6'd40, 32'd9,        32'd9,        32'd9,        32'h50,       4'd5, 32'd0,        1'b0, 32'h54});

        // Reset state while rst is held low.
        #1;
        chk("rst_valid", 32'(bus.exc_valid), 32'd0);
        chk("rst_value", bus.exc_value, 32'd0);
        chk("rst_target", bus.exc_target, 32'd0);
        chk("rst_next_full", 32'(alu_next_full), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_valid", 32'(bus.exc_valid), 32'd0);
            chk("idle_next_full", 32'(alu_next_full), 32'd0);
        end

        // Compute table: each op dispatched alone with the bus granted.
        bus.cdb_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].imm, vecs[i].pc, vecs[i].rob);
            @(negedge clk);
            drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
            chk($sformatf("v%0d_valid", i), 32'(bus.exc_valid), 32'd1);
            chk($sformatf("v%0d_rob", i), 32'(bus.exc_RobId), 32'(vecs[i].rob));
            chk($sformatf("v%0d_value", i), bus.exc_value, vecs[i].exp_value);
            chk($sformatf("v%0d_jump", i), 32'(bus.exc_jump), 32'(vecs[i].exp_jump));
            chk($sformatf("v%0d_target", i), bus.exc_target, vecs[i].exp_target);
            @(negedge clk);
            chk($sformatf("v%0d_popped", i), 32'(bus.exc_valid), 32'd0);
        end

        // Back-to-back dispatch with no grant: fill, then overflow on the fifth.
        bus.cdb_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 6'd0, 32'(k), 32'd0, 32'd0, 32'd0, 4'(k));
            @(negedge clk);
            chk($sformatf("fill%0d_next_full", k), 32'(alu_next_full), (k >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_ovf", k), 32'(ovf_err), (k == 5) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_head", k), 32'(bus.exc_RobId), 32'd1);
        end
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        bus.cdb_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(bus.exc_valid), 32'd1);
            chk($sformatf("drain%0d_rob", k), 32'(bus.exc_RobId), 32'(k));
            chk($sformatf("drain%0d_value", k), bus.exc_value, 32'(k));
            @(negedge clk);
        end
        chk("drain_empty", 32'(bus.exc_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(ovf_err), 32'd1);

        // Flush with three queued and a concurrent dispatch.
        bus.cdb_ready = 1'b0;
        for (int k = 7; k <= 9; k++) begin
            drive(1'b1, 6'd0, 32'(k), 32'd0, 32'd0, 32'd0, 4'(k));
            @(negedge clk);
        end
        chk("preflush_next_full", 32'(alu_next_full), 32'd1);
        jump_flag = 1'b1;
        drive(1'b1, 6'd0, 32'd10, 32'd0, 32'd0, 32'd0, 4'd10);
        @(negedge clk);
        jump_flag = 1'b0;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        chk("flush_valid", 32'(bus.exc_valid), 32'd0);
        chk("flush_next_full", 32'(alu_next_full), 32'd0);
        chk("flush_ovf_kept", 32'(ovf_err), 32'd1);
        bus.cdb_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("flush_no_bcast", 32'(bus.exc_valid), 32'd0);
        end

        // Async reset mid-operation clears without a clock edge.
        bus.cdb_ready = 1'b0;
        drive(1'b1, 6'd0, 32'd3, 32'd0, 32'd0, 32'd0, 4'd6);
        @(negedge clk);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        chk("pre_arst_valid", 32'(bus.exc_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.exc_valid), 32'd0);
        chk("arst_ovf", 32'(ovf_err), 32'd0);
        chk("arst_rob", 32'(bus.exc_RobId), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Freeze: rdy low for three edges blocks pop and push.
        drive(1'b1, 6'd0, 32'd1, 32'd0, 32'd0, 32'd0, 4'd1);
        @(negedge clk);
        drive(1'b1, 6'd0, 32'd2, 32'd0, 32'd0, 32'd0, 4'd2);
        @(negedge clk);
        rdy = 1'b0;
        bus.cdb_ready = 1'b1;
        drive(1'b1, 6'd0, 32'd15, 32'd0, 32'd0, 32'd0, 4'd15);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("frz_valid", 32'(bus.exc_valid), 32'd1);
            chk("frz_rob", 32'(bus.exc_RobId), 32'd1);
        end
        rdy = 1'b1;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk("resume_rob", 32'(bus.exc_RobId), 32'd2);
        chk("resume_value", bus.exc_value, 32'd2);
        @(negedge clk);
        chk("resume_empty", 32'(bus.exc_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
